countdown_from15: RTL and testbench

Loadable down-counter: the counting-down counterpart of the team's up-counter-till-15 (counter_till15).
- Accepts a start request with a load value.
- Decrements to zero under an enable.
- Signals terminal count with a one-cycle done pulse.
- Used as a programmable delay/timeout generator beside the up-counter in the practice design set.

---
 rtl/countdown_from15.sv | 151 +++++++++++++++
 tb/tb_countdown_from15.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/countdown_from15.sv
`default_nettype none
// ============================================================================
//  Module      : countdown_from15
//  Description : Loadable down-counter with a one-cycle terminal-count pulse.
//                A start request loads load_val; the counter then decrements
//                once per enabled cycle until it reaches zero, at which point
//                done pulses for exactly one cycle.  Intended as a
//                programmable delay / timeout generator.
//
//  Ports       : clk          - single clock, all state on rising edge
//                reset        - synchronous, active-low reset
//                start        - load request, samples load_val
//                load_val     - countdown start value (unsigned, WIDTH bits)
//                enable       - decrement enable while running (0 = pause)
//                auto_reload  - (AUTO_RELOAD_EN builds only) reload load_val
//                               at terminal count instead of stopping
//                count        - current counter value, registered
//                busy         - high while running, registered
//                done         - one-cycle terminal-count pulse, registered
//                zero         - combinational, count == 0
//
//  Build macro : AUTO_RELOAD_EN - adds the auto_reload input and the
//                periodic reload behaviour at terminal count.
//
//  Revision    : 1.0 - initial release
// ============================================================================
module countdown_from15 #(
   parameter int               WIDTH   = 4,
   parameter logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}}
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] load_val,
   input  logic             enable,
`ifdef AUTO_RELOAD_EN
   input  logic             auto_reload,
`endif
   output logic [WIDTH-1:0] count,
   output logic             busy,
   output logic             done,
   output logic             zero
);

   localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] count_nxt;
   logic             done_nxt;
   logic             reload_at_terminal;

   // Reloading at terminal count only makes sense with a non-zero reload
   // value; a zero value falls back to the normal stop-at-zero path.
`ifdef AUTO_RELOAD_EN
   assign reload_at_terminal = auto_reload && (load_val != '0);
`else
   assign reload_at_terminal = 1'b0;
`endif

   // ------------------------------------------------------------------------
   // Next-state / next-output logic
   // ------------------------------------------------------------------------
   always_comb begin
      state_nxt = state;
      count_nxt = count;
      done_nxt  = 1'b0;

      case (state)
         ST_IDLE: begin
            if (start) begin
               if (load_val != '0) begin
                  count_nxt = load_val;
                  state_nxt = ST_RUN;
               end else begin
                  // A zero load completes immediately with a done pulse.
                  count_nxt = '0;
                  state_nxt = ST_DONE;
                  done_nxt  = 1'b1;
               end
            end
         end

         ST_RUN: begin
            // A restart request wins over a decrement in the same cycle.
            if (start) begin
               if (load_val != '0) begin
                  count_nxt = load_val;
                  state_nxt = ST_RUN;
               end else begin
                  count_nxt = '0;
                  state_nxt = ST_DONE;
                  done_nxt  = 1'b1;
               end
            end else if (enable) begin
               if (count > ONE) begin
                  count_nxt = count - ONE;
               end else if (reload_at_terminal) begin
                  count_nxt = load_val;
                  state_nxt = ST_RUN;
                  done_nxt  = 1'b1;
               end else begin
                  // Terminal edge: count is 1 here, never 0, so the
                  // counter cannot wrap.
                  count_nxt = '0;
                  state_nxt = ST_DONE;
                  done_nxt  = 1'b1;
               end
            end
         end

         ST_DONE: begin
            // Single-cycle state; start is deliberately ignored here.
            count_nxt = '0;
            state_nxt = ST_IDLE;
         end

         default: begin
            state_nxt = ST_IDLE;
            count_nxt = MAX_VAL;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // State and output registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= ST_IDLE;
         count <= MAX_VAL;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         state <= state_nxt;
         count <= count_nxt;
         busy  <= (state_nxt == ST_RUN);
         done  <= done_nxt;
      end
   end

   assign zero = (count == '0);

endmodule
`default_nettype wire

// File: tb/tb_countdown_from15.sv
`default_nettype none
// ============================================================================
//  Module      : tb_countdown_from15
//  Description : Directed self-checking bench for countdown_from15.
//                Define AUTO_RELOAD_EN to also cover the auto-reload mode.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_countdown_from15;

   localparam int WIDTH = 4;

   logic             clk;
   logic             reset;
   logic             start;
   logic [WIDTH-1:0] load_val;
   logic             enable;
`ifdef AUTO_RELOAD_EN
   logic             auto_reload;
`endif
   logic [WIDTH-1:0] count;
   logic             busy;
   logic             done;
   logic             zero;

   int pass_cnt  = 0;
   int total_cnt = 0;

   countdown_from15 #(
      .WIDTH   (WIDTH),
      .MAX_VAL (4'b1111)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .load_val    (load_val),
      .enable      (enable),
`ifdef AUTO_RELOAD_EN
      .auto_reload (auto_reload),
`endif
      .count       (count),
      .busy        (busy),
      .done        (done),
      .zero        (zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total_cnt++;
      if (obs === exp) pass_cnt++;
      else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
   endtask

   // Advance one rising edge, then settle before sampling.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_all(input string tag, input int c, input int b, input int d, input int z);
      check({tag, ".count"}, 32'(count), 32'(c));
      check({tag, ".busy"},  32'(busy),  32'(b));
      check({tag, ".done"},  32'(done),  32'(d));
      check({tag, ".zero"},  32'(zero),  32'(z));
   endtask

   initial begin
      reset    = 1'b0;
      start    = 1'b0;
      load_val = '0;
      enable   = 1'b0;
`ifdef AUTO_RELOAD_EN
      auto_reload = 1'b0;
`endif
      // Reset for two edges.
      tick();
      tick();
      expect_all("reset", 15, 0, 0, 0);
      reset  = 1'b1;
      enable = 1'b1;
      tick();
      expect_all("idle_hold", 15, 0, 0, 0);

      // Full countdown from 15.
      start = 1'b1; load_val = 4'd15;
      tick();
      expect_all("full_load", 15, 1, 0, 0);
      start = 1'b0;
      for (int i = 14; i >= 1; i--) begin
         tick();
         expect_all($sformatf("full_%0d", i), i, 1, 0, 0);
      end
      tick();
      expect_all("full_term", 0, 0, 1, 1);
      tick();
      expect_all("full_idle", 0, 0, 0, 1);

      // Pause: load 5, hold at 3 for three cycles.
      start = 1'b1; load_val = 4'd5;
      tick();
      expect_all("pause_load", 5, 1, 0, 0);
      start = 1'b0;
      tick();
      expect_all("pause_4", 4, 1, 0, 0);
      tick();
      expect_all("pause_3", 3, 1, 0, 0);
      enable = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         expect_all($sformatf("pause_hold%0d", i), 3, 1, 0, 0);
      end
      enable = 1'b1;
      tick();
      expect_all("pause_2", 2, 1, 0, 0);
      tick();
      expect_all("pause_1", 1, 1, 0, 0);
      tick();
      expect_all("pause_term", 0, 0, 1, 1);
      tick();
      expect_all("pause_idle", 0, 0, 0, 1);

      // Restart in RUN at count 6 with load 9: no decrement that cycle.
      start = 1'b1; load_val = 4'd8;
      tick();
      start = 1'b0;
      tick();
      tick();
      expect_all("rst_at6", 6, 1, 0, 0);
      start = 1'b1; load_val = 4'd9;
      tick();
      expect_all("restart", 9, 1, 0, 0);
      start = 1'b0;
      for (int i = 8; i >= 1; i--) begin
         tick();
         check($sformatf("restart_%0d", i), 32'(count), 32'(i));
      end
      // Terminal edge, then assert start while in DONE: must be ignored.
      tick();
      expect_all("restart_term", 0, 0, 1, 1);
      start = 1'b1; load_val = 4'd4;
      tick();
      expect_all("done_ignores_start", 0, 0, 0, 1);
      tick();
      expect_all("idle_restart", 4, 1, 0, 0);

      // Reset mid-run: restart with 12, four decrements, then reset.
      load_val = 4'd12;
      tick();
      expect_all("mid_load", 12, 1, 0, 0);
      start = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      expect_all("mid_8", 8, 1, 0, 0);
      reset = 1'b0;
      tick();
      expect_all("mid_reset", 15, 0, 0, 0);
      reset = 1'b1;
      tick();
      expect_all("mid_after", 15, 0, 0, 0);

      // Zero load in IDLE: immediate done, busy never asserted.
      start = 1'b1; load_val = 4'd0;
      tick();
      expect_all("zero_load", 0, 0, 1, 1);
      start = 1'b0;
      tick();
      expect_all("zero_idle", 0, 0, 0, 1);
      tick();
      expect_all("zero_idle_en", 0, 0, 0, 1);

`ifdef AUTO_RELOAD_EN
      // Auto-reload: 3,2,1,3,2,1,... with done at each reload.
      auto_reload = 1'b1;
      start = 1'b1; load_val = 4'd3;
      tick();
      expect_all("ar_load", 3, 1, 0, 0);
      start = 1'b0;
      for (int r = 0; r < 2; r++) begin
         tick();
         expect_all($sformatf("ar%0d_2", r), 2, 1, 0, 0);
         tick();
         expect_all($sformatf("ar%0d_1", r), 1, 1, 0, 0);
         tick();
         expect_all($sformatf("ar%0d_reload", r), 3, 1, 1, 0);
      end
      auto_reload = 1'b0;
      tick();
      expect_all("ar_off_2", 2, 1, 0, 0);
      tick();
      expect_all("ar_off_1", 1, 1, 0, 0);
      tick();
      expect_all("ar_off_term", 0, 0, 1, 1);
      tick();
      expect_all("ar_off_idle", 0, 0, 0, 1);
`endif

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   // Global watchdog so the run always terminates.
   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
